// File: rtl/bfis_pkg.sv
// Shared definitions for the vector-search datapath: frame header, default word width
// and the result-frame state encoding.
package bfis_pkg;

  localparam logic [7:0]  FRAME_HDR      = 8'hA5;
  localparam int unsigned DEFAULT_WORD_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StCnt,
    StPayload,
    StCsum
  } frame_state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter. A new byte may be started in the cycle o_last is high, which
// lets the caller chain bytes with no idle bits between them.
module uart_byte_tx #(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_byte,
  input  logic       i_start,
  output logic       o_txd,
  output logic       o_ready,
  output logic       o_last
);

  localparam int unsigned BaudW = $clog2(BAUD_DIV);

  logic [BaudW-1:0] r_baud;
  logic [3:0]       r_bit;
  logic [9:0]       r_shift;
  logic             r_active;
  logic             w_bit_end;

  assign w_bit_end = r_active && (r_baud == BaudW'(BAUD_DIV - 1));
  assign o_last    = w_bit_end && (r_bit == 4'd9);
  assign o_ready   = !r_active || o_last;
  // The line is driven straight from a flop; the shifter back-fills with ones so it idles high.
  assign o_txd     = r_shift[0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '1;
    end else if (i_start && o_ready) begin
      r_active <= 1'b1;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= {1'b1, i_byte, 1'b0};
    end else if (r_active) begin
      if (w_bit_end) begin
        r_baud <= '0;
        if (r_bit == 4'd9) begin
          r_active <= 1'b0;
          r_bit    <= '0;
          r_shift  <= '1;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_shift <= {1'b1, r_shift[9:1]};
        end
      end else begin
        r_baud <= r_baud + BaudW'(1);
      end
    end
  end

endmodule

// File: rtl/topk_uart_tx.sv
// Captures a top-k result vector and streams it as a framed, XOR-checksummed byte
// sequence (header, count, little-endian words, checksum) on a UART TX line.
module topk_uart_tx
  import bfis_pkg::*;
#(
  parameter int unsigned K_MAX    = 5,
  parameter int unsigned WORD_W   = DEFAULT_WORD_W,
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [K_MAX-1:0][WORD_W-1:0]   top_k_in,
  input  logic [$clog2(K_MAX+1)-1:0]     k_in,
  input  logic                           valid_in,
  output logic                           uart_txd,
  output logic                           busy_out,
  output logic                           frame_done_out,
  output logic                           dropped_out
);

  localparam int unsigned CntW  = $clog2(K_MAX + 1);
  localparam int unsigned Bpw   = WORD_W / 8;
  localparam int unsigned WIdxW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int unsigned BIdxW = (Bpw > 1) ? $clog2(Bpw) : 1;

  frame_state_e                 r_state;
  frame_state_e                 w_state_nxt;
  logic [K_MAX-1:0][WORD_W-1:0] r_words;
  logic [CntW-1:0]              r_n;
  logic [WIdxW-1:0]             r_widx;
  logic [BIdxW-1:0]             r_bidx;
  logic [7:0]                   r_csum;
  logic                         r_dropped;

  logic [CntW-1:0]  w_n_in;
  logic [7:0]       w_cnt_byte;
  logic             w_last_word;
  logic             w_last_byte;
  logic [WIdxW-1:0] w_adv_widx;
  logic [BIdxW-1:0] w_adv_bidx;
  logic [WIdxW-1:0] w_sel_widx;
  logic [BIdxW-1:0] w_sel_bidx;
  logic [7:0]       w_pay_byte;
  logic [WIdxW-1:0] w_widx_nxt;
  logic [BIdxW-1:0] w_bidx_nxt;
  logic [7:0]       w_csum_nxt;
  logic [7:0]       w_tx_byte;
  logic             w_start;
  logic             w_accept;
  logic             w_done;
  logic             w_txd;
  logic             w_ready;
  logic             w_last;

  assign w_n_in      = (32'(k_in) > K_MAX) ? CntW'(K_MAX) : k_in;
  assign w_cnt_byte  = 8'(r_n);
  assign w_last_word = (32'(r_widx) + 32'd1) == 32'(r_n);
  assign w_last_byte = (r_bidx == BIdxW'(Bpw - 1));

  always_comb begin
    w_adv_widx = r_widx;
    w_adv_bidx = r_bidx + BIdxW'(1);
    if (w_last_byte) begin
      w_adv_widx = r_widx + WIdxW'(1);
      w_adv_bidx = '0;
    end
  end

  // Leaving CNT the first payload byte is at the freshly cleared indices; inside
  // PAYLOAD the byte handed over next is the one after the byte in flight.
  assign w_sel_widx = (r_state == StPayload) ? w_adv_widx : r_widx;
  assign w_sel_bidx = (r_state == StPayload) ? w_adv_bidx : r_bidx;
  assign w_pay_byte = r_words[w_sel_widx][8*w_sel_bidx +: 8];

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_tx_byte   = FRAME_HDR;
    w_csum_nxt  = r_csum;
    w_widx_nxt  = r_widx;
    w_bidx_nxt  = r_bidx;
    case (r_state)
      StIdle: begin
        if (valid_in && w_ready) begin
          w_accept    = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = StHdr;
        end
      end
      StHdr: begin
        if (w_last) begin
          w_start     = 1'b1;
          w_tx_byte   = w_cnt_byte;
          w_csum_nxt  = w_cnt_byte;
          w_state_nxt = StCnt;
        end
      end
      StCnt: begin
        if (w_last) begin
          w_start = 1'b1;
          if (r_n == '0) begin
            w_tx_byte   = r_csum;
            w_state_nxt = StCsum;
          end else begin
            w_tx_byte   = w_pay_byte;
            w_csum_nxt  = r_csum ^ w_pay_byte;
            w_state_nxt = StPayload;
          end
        end
      end
      StPayload: begin
        if (w_last) begin
          w_start = 1'b1;
          if (w_last_byte && w_last_word) begin
            w_tx_byte   = r_csum;
            w_state_nxt = StCsum;
          end else begin
            w_tx_byte  = w_pay_byte;
            w_csum_nxt = r_csum ^ w_pay_byte;
            w_widx_nxt = w_adv_widx;
            w_bidx_nxt = w_adv_bidx;
          end
        end
      end
      StCsum: begin
        if (w_last) begin
          w_done      = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_words   <= '0;
      r_n       <= '0;
      r_widx    <= '0;
      r_bidx    <= '0;
      r_csum    <= '0;
      r_dropped <= 1'b0;
    end else begin
      if (w_accept) begin
        r_words <= top_k_in;
        r_n     <= w_n_in;
        r_widx  <= '0;
        r_bidx  <= '0;
        r_csum  <= '0;
      end else begin
        r_widx <= w_widx_nxt;
        r_bidx <= w_bidx_nxt;
        r_csum <= w_csum_nxt;
      end
      r_dropped <= valid_in && (r_state != StIdle);
    end
  end

  uart_byte_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_byte_tx (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_byte  (w_tx_byte),
    .i_start (w_start),
    .o_txd   (w_txd),
    .o_ready (w_ready),
    .o_last  (w_last)
  );

  assign uart_txd       = w_txd;
  assign busy_out       = (r_state != StIdle);
  assign frame_done_out = w_done;
  assign dropped_out    = r_dropped;

endmodule

// File: tb/tb_topk_uart_tx.sv
// Randomized bench for topk_uart_tx: a line receiver decodes bytes and compares them
// with a frame built from the packet rules; timing and pulse counts are also checked.
module tb_topk_uart_tx;

  localparam int unsigned KMax  = 5;
  localparam int unsigned WordW = 32;
  localparam int unsigned Baud  = 4;
  localparam int unsigned Bpw   = WordW / 8;
  localparam int unsigned KW    = $clog2(KMax + 1);

  logic                        clk = 1'b0;
  logic                        rst_in = 1'b1;
  logic [KMax-1:0][WordW-1:0]  top_k_in = '0;
  logic [KW-1:0]               k_in = '0;
  logic                        valid_in = 1'b0;
  logic                        uart_txd;
  logic                        busy_out;
  logic                        frame_done_out;
  logic                        dropped_out;

  topk_uart_tx #(
    .K_MAX    (KMax),
    .WORD_W   (WordW),
    .BAUD_DIV (Baud)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .top_k_in       (top_k_in),
    .k_in           (k_in),
    .valid_in       (valid_in),
    .uart_txd       (uart_txd),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .dropped_out    (dropped_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_total = 0;
  int drop_total = 0;
  int done_exp   = 0;
  int drops_exp  = 0;
  int t1         = 0;
  int exp_n      = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] wds[KMax];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h @cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    done_total <= done_total + (frame_done_out ? 1 : 0);
    drop_total <= drop_total + (dropped_out ? 1 : 0);
  end

  // Line receiver: samples mid-bit on falling clock edges.
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  int         rx_idx = 0;
  logic [7:0] rx_byte = '0;

  always @(negedge clk) begin
    if (rst_in) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (uart_txd == 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % Baud == Baud / 2) begin
        rx_idx = rx_cnt / Baud;
        if (rx_idx == 0) begin
          chk("rx_start_bit", 32'(uart_txd), 32'd0);
        end else if (rx_idx <= 8) begin
          rx_byte[rx_idx-1] = uart_txd;
        end else begin
          chk("rx_stop_bit", 32'(uart_txd), 32'd1);
          rx_q.push_back(rx_byte);
          rx_on = 1'b0;
        end
      end
    end
  end

  // Reference frame straight from the packet rules.
  task automatic build_exp(input int k);
    logic [7:0] cs;
    logic [7:0] b;
    exp_q.delete();
    exp_n = (k > int'(KMax)) ? int'(KMax) : k;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(exp_n));
    cs = 8'(exp_n);
    for (int w = 0; w < exp_n; w++) begin
      for (int i = 0; i < int'(Bpw); i++) begin
        b = 8'(wds[w] >> (8 * i));
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic randomize_words();
    for (int i = 0; i < int'(KMax); i++) wds[i] = $urandom;
  endtask

  // Called at a falling edge; returns at the falling edge of cycle t+1.
  task automatic start_frame(input int k);
    build_exp(k);
    rx_q.delete();
    for (int i = 0; i < int'(KMax); i++) top_k_in[i] = wds[i];
    k_in     = KW'(k);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    for (int i = 0; i < int'(KMax); i++) top_k_in[i] = $urandom;
    k_in = KW'($urandom_range(0, 7));
    t1   = cyc;
    chk("hdr_busy", 32'(busy_out), 32'd1);
    chk("hdr_start_bit", 32'(uart_txd), 32'd0);
  endtask

  task automatic inject_drop();
    for (int i = 0; i < int'(KMax); i++) top_k_in[i] = $urandom;
    k_in     = KW'($urandom_range(0, 7));
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk("drop_pulse", 32'(dropped_out), 32'd1);
    drops_exp++;
  endtask

  // Returns at the falling edge of the cycle after frame_done_out.
  task automatic finish_frame(input bit drop_at_done);
    int waited = 0;
    while (!frame_done_out && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    chk("done_seen", 32'(frame_done_out), 32'd1);
    chk("frame_len", 32'(cyc - t1 + 1), 32'(10 * Baud * (3 + Bpw * exp_n)));
    chk("busy_at_done", 32'(busy_out), 32'd1);
    done_exp++;
    if (drop_at_done) valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk("busy_after_done", 32'(busy_out), 32'd0);
    if (drop_at_done) begin
      chk("drop_at_done", 32'(dropped_out), 32'd1);
      drops_exp++;
    end
    chk("rx_len", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("rx_byte%0d", i),
          (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
  endtask

  initial begin
    int bad;
    int k;
    rst_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", 32'(uart_txd), 32'd1);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(frame_done_out), 32'd0);
    chk("rst_dropped", 32'(dropped_out), 32'd0);
    rst_in = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (frame_done_out || dropped_out || !uart_txd || busy_out) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    randomize_words();
    wds[0] = 32'h1122_3344;
    wds[1] = 32'hDEAD_BEEF;
    start_frame(2);
    finish_frame(1'b0);

    // Accepted in the very cycle after busy falls.
    start_frame(0);
    finish_frame(1'b0);

    randomize_words();
    start_frame(7);
    repeat ($urandom_range(50, 400)) @(negedge clk);
    inject_drop();
    finish_frame(1'b1);

    for (int r = 0; r < 6; r++) begin
      randomize_words();
      k = $urandom_range(0, 7);
      start_frame(k);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 100)) @(negedge clk);
        inject_drop();
      end
      finish_frame(1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    randomize_words();
    start_frame(3);
    while (cyc - t1 < int'(10 * Baud * 5) + 13) @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    chk("midrst_txd", 32'(uart_txd), 32'd1);
    chk("midrst_busy", 32'(busy_out), 32'd0);
    chk("midrst_done", 32'(frame_done_out), 32'd0);
    @(negedge clk);
    rst_in = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (frame_done_out || !uart_txd || busy_out) bad++;
    end
    chk("post_rst_quiet", 32'(bad), 32'd0);

    randomize_words();
    start_frame(5);
    finish_frame(1'b0);

    repeat (3) @(negedge clk);
    chk("done_total", 32'(done_total), 32'(done_exp));
    chk("drop_total", 32'(drop_total), 32'(drops_exp));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
